// File: rtl/ps2_char_buffer_if.sv
// Handshake bundle between the PS/2 front end, the display read port and ps2_char_buffer.
// master drives key codes and read requests; slave is the buffer.
interface ps2_char_buffer_if #(
    parameter int IDX_W = 4
);
    logic [7:0]     PS2_code;
    logic           PS2_code_ready;
    logic           PS2_make_code;
    logic [IDX_W-1:0] Rd_index;
    logic           Rd_valid;
    logic [5:0]     Rd_char;
    logic [IDX_W:0] Char_count;
    logic           Buffer_full;
    logic           Overflow;

    modport master (
        output PS2_code, PS2_code_ready, PS2_make_code, Rd_index, Rd_valid,
        input  Rd_char, Char_count, Buffer_full, Overflow
    );
    modport slave (
        input  PS2_code, PS2_code_ready, PS2_make_code, Rd_index, Rd_valid,
        output Rd_char, Char_count, Buffer_full, Overflow
    );
endinterface

// File: rtl/ps2_char_buffer.sv
// Text line buffer: PS/2 make codes -> char_rom addresses, stored in a NUM_CHARS entry line
// with backspace, enter-to-clear sweep and a registered read port for the display stage.
module ps2_char_buffer #(
    parameter int NUM_CHARS = 16,
    parameter int IDX_W     = 4
) (
    input  logic Clock_50,
    input  logic Reset,
    ps2_char_buffer_if.slave bus
);
    localparam logic [5:0]       SPACE    = 6'o40;
    localparam logic [IDX_W:0]   FULL_CNT = (IDX_W+1)'(NUM_CHARS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHARS - 1);

    typedef enum logic {IDLE, CLEAR} state_e;

    state_e           state_q, state_d;
    logic [5:0]       mem_q [NUM_CHARS];
    logic [5:0]       mem_d [NUM_CHARS];
    logic [IDX_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [IDX_W-1:0] clr_idx_q, clr_idx_d;
    logic [IDX_W:0]   count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             ready_q, ready_d;
    logic [5:0]       rd_char_q, rd_char_d;

    logic       key_evt, printable, is_bs, is_enter, full;
    logic [5:0] key_char;

    // Returns {printable, char_rom address}; non-printable codes give 0.
    function automatic logic [6:0] xlat(input logic [7:0] c);
        case (c)
            8'h45: xlat = {1'b1, 6'o60};  8'h16: xlat = {1'b1, 6'o61};
            8'h1E: xlat = {1'b1, 6'o62};  8'h26: xlat = {1'b1, 6'o63};
            8'h25: xlat = {1'b1, 6'o64};  8'h2E: xlat = {1'b1, 6'o65};
            8'h36: xlat = {1'b1, 6'o66};  8'h3D: xlat = {1'b1, 6'o67};
            8'h3E: xlat = {1'b1, 6'o70};  8'h46: xlat = {1'b1, 6'o71};
            8'h1C: xlat = {1'b1, 6'o01};  8'h32: xlat = {1'b1, 6'o02};
            8'h21: xlat = {1'b1, 6'o03};  8'h23: xlat = {1'b1, 6'o04};
            8'h24: xlat = {1'b1, 6'o05};  8'h2B: xlat = {1'b1, 6'o06};
            8'h34: xlat = {1'b1, 6'o07};  8'h33: xlat = {1'b1, 6'o10};
            8'h43: xlat = {1'b1, 6'o11};  8'h3B: xlat = {1'b1, 6'o12};
            8'h42: xlat = {1'b1, 6'o13};  8'h4B: xlat = {1'b1, 6'o14};
            8'h3A: xlat = {1'b1, 6'o15};  8'h31: xlat = {1'b1, 6'o16};
            8'h44: xlat = {1'b1, 6'o17};  8'h4D: xlat = {1'b1, 6'o20};
            8'h15: xlat = {1'b1, 6'o21};  8'h2D: xlat = {1'b1, 6'o22};
            8'h1B: xlat = {1'b1, 6'o23};  8'h2C: xlat = {1'b1, 6'o24};
            8'h3C: xlat = {1'b1, 6'o25};  8'h2A: xlat = {1'b1, 6'o26};
            8'h1D: xlat = {1'b1, 6'o27};  8'h22: xlat = {1'b1, 6'o30};
            8'h35: xlat = {1'b1, 6'o31};  8'h1A: xlat = {1'b1, 6'o32};
            8'h29: xlat = {1'b1, SPACE};
            default: xlat = 7'd0;
        endcase
    endfunction

    always_comb begin
        key_evt               = bus.PS2_code_ready & ~ready_q & bus.PS2_make_code;
        {printable, key_char} = xlat(bus.PS2_code);
        is_bs                 = (bus.PS2_code == 8'h66);
        is_enter              = (bus.PS2_code == 8'h5A);
        full                  = (count_q == FULL_CNT);

        state_d   = state_q;
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        clr_idx_d = clr_idx_q;
        count_d   = count_q;
        ovf_d     = ovf_q;
        ready_d   = bus.PS2_code_ready;
        // Read sees pre-edge contents, so a same-cycle write returns the old entry.
        rd_char_d = bus.Rd_valid ? mem_q[bus.Rd_index] : SPACE;

        case (state_q)
            IDLE: begin
                if (key_evt) begin
                    if (printable) begin
                        if (full) begin
                            ovf_d = 1'b1;
                        end else begin
                            mem_d[wr_ptr_q] = key_char;
                            wr_ptr_d        = wr_ptr_q + IDX_W'(1);
                            count_d         = count_q + (IDX_W+1)'(1);
                        end
                    end else if (is_bs) begin
                        if (count_q != '0) begin
                            mem_d[wr_ptr_q - IDX_W'(1)] = SPACE;
                            wr_ptr_d = wr_ptr_q - IDX_W'(1);
                            count_d  = count_q - (IDX_W+1)'(1);
                        end
                    end else if (is_enter) begin
                        state_d   = CLEAR;
                        clr_idx_d = '0;
                    end
                end
            end
            CLEAR: begin
                // Key events are dropped for the whole sweep.
                mem_d[clr_idx_q] = SPACE;
                clr_idx_d        = clr_idx_q + IDX_W'(1);
                if (clr_idx_q == LAST_IDX) begin
                    state_d  = IDLE;
                    wr_ptr_d = '0;
                    count_d  = '0;
                    ovf_d    = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock_50) begin
        if (Reset) begin
            state_q   <= IDLE;
            for (int i = 0; i < NUM_CHARS; i++) mem_q[i] <= SPACE;
            wr_ptr_q  <= '0;
            clr_idx_q <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            ready_q   <= 1'b0;
            rd_char_q <= SPACE;
        end else begin
            state_q   <= state_d;
            mem_q     <= mem_d;
            wr_ptr_q  <= wr_ptr_d;
            clr_idx_q <= clr_idx_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            ready_q   <= ready_d;
            rd_char_q <= rd_char_d;
        end
    end

    assign bus.Rd_char     = rd_char_q;
    assign bus.Char_count  = count_q;
    assign bus.Buffer_full = full;
    assign bus.Overflow    = ovf_q;
endmodule

// File: tb/tb_ps2_char_buffer.sv
// Scoreboard bench for ps2_char_buffer: expected line contents kept in a small model,
// read-port expectations queued at request time and compared when Rd_char is sampled.
module tb_ps2_char_buffer;
    localparam int N = 16;
    localparam logic [5:0] SP = 6'o40;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #10 clk = ~clk;

    ps2_char_buffer_if #(.IDX_W(4)) bus ();
    ps2_char_buffer #(.NUM_CHARS(N), .IDX_W(4)) dut (.Clock_50(clk), .Reset(rst), .bus(bus));

    int n_tests = 0;
    int n_fail  = 0;
    logic [5:0] exp_mem [N];
    int         exp_cnt;
    logic       exp_ovf;
    logic [5:0] exp_q [$];
    logic [5:0] got [N];
    logic [5:0] e;

    function automatic logic [6:0] exp_status();
        return {5'(exp_cnt), exp_cnt == N, exp_ovf};
    endfunction

    function automatic logic [6:0] dut_status();
        return {bus.Char_count, bus.Buffer_full, bus.Overflow};
    endfunction

    task automatic m_put(input logic [5:0] ch);
        if (exp_cnt < N) begin exp_mem[exp_cnt] = ch; exp_cnt++; end
        else exp_ovf = 1'b1;
    endtask

    task automatic m_bs();
        if (exp_cnt > 0) begin exp_cnt--; exp_mem[exp_cnt] = SP; end
    endtask

    task automatic m_clr();
        for (int i = 0; i < N; i++) exp_mem[i] = SP;
        exp_cnt = 0;
        exp_ovf = 1'b0;
    endtask

    // One ready pulse of one cycle; returns on the negedge after the following edge.
    task automatic key(input logic [7:0] code, input logic make);
        @(negedge clk);
        bus.PS2_code = code; bus.PS2_make_code = make; bus.PS2_code_ready = 1'b1;
        @(negedge clk);
        bus.PS2_code_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic press(input logic [7:0] code, input logic [5:0] ch);
        key(code, 1'b1);
        m_put(ch);
    endtask

    task automatic enter_and_wait();
        key(8'h5A, 1'b1);
        repeat (15) @(negedge clk);
        m_clr();
    endtask

    task automatic read_line();
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            bus.Rd_valid = 1'b1;
            bus.Rd_index = 4'(i);
            exp_q.push_back(exp_mem[i]);
            @(posedge clk);
            #1 got[i] = bus.Rd_char;
        end
        @(negedge clk);
        bus.Rd_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_clr();
        n_tests++;
        if (dut_status() !== exp_status()) begin
            n_fail++; $display("FAIL reset_status got %b want %b", dut_status(), exp_status());
        end
        n_tests++;
        if (bus.Rd_char !== SP) begin
            n_fail++; $display("FAIL reset_rd_char got %o want %o", bus.Rd_char, SP);
        end
        read_line();
        for (int i = 0; i < N; i++) begin
            e = exp_q.pop_front(); n_tests++;
            if (got[i] !== e) begin n_fail++; $display("FAIL reset_entry%0d got %o want %o", i, got[i], e); end
        end
    endtask

    task automatic test_basic();
        press(8'h16, 6'o61);
        press(8'h1E, 6'o62);
        press(8'h26, 6'o63);
        n_tests++;
        if (dut_status() !== exp_status()) begin
            n_fail++; $display("FAIL basic_status got %b want %b", dut_status(), exp_status());
        end
        read_line();
        for (int i = 0; i < N; i++) begin
            e = exp_q.pop_front(); n_tests++;
            if (got[i] !== e) begin n_fail++; $display("FAIL basic_entry%0d got %o want %o", i, got[i], e); end
        end
    endtask

    task automatic test_hold_break();
        @(negedge clk);
        bus.PS2_code = 8'h45; bus.PS2_make_code = 1'b1; bus.PS2_code_ready = 1'b1;
        repeat (10) @(negedge clk);
        bus.PS2_code_ready = 1'b0;
        m_put(6'o60);
        key(8'h45, 1'b0);   // break code
        key(8'h76, 1'b1);   // unmapped code
        n_tests++;
        if (dut_status() !== exp_status()) begin
            n_fail++; $display("FAIL hold_status got %b want %b", dut_status(), exp_status());
        end
        read_line();
        for (int i = 0; i < N; i++) begin
            e = exp_q.pop_front(); n_tests++;
            if (got[i] !== e) begin n_fail++; $display("FAIL hold_entry%0d got %o want %o", i, got[i], e); end
        end
    endtask

    task automatic test_clear();
        logic [6:0] mid;
        press(8'h1C, 6'o01);
        mid = exp_status();
        @(negedge clk);
        bus.PS2_code = 8'h5A; bus.PS2_make_code = 1'b1; bus.PS2_code_ready = 1'b1;
        @(negedge clk);
        bus.PS2_code_ready = 1'b0;
        repeat (2) @(negedge clk);
        bus.PS2_code = 8'h16; bus.PS2_code_ready = 1'b1;   // lands on sweep cycle 3
        @(negedge clk);
        bus.PS2_code_ready = 1'b0;
        repeat (12) @(negedge clk);
        n_tests++;
        if (dut_status() !== mid) begin
            n_fail++; $display("FAIL clear_cycle15_status got %b want %b", dut_status(), mid);
        end
        @(negedge clk);
        m_clr();
        n_tests++;
        if (dut_status() !== exp_status()) begin
            n_fail++; $display("FAIL clear_done_status got %b want %b", dut_status(), exp_status());
        end
        read_line();
        for (int i = 0; i < N; i++) begin
            e = exp_q.pop_front(); n_tests++;
            if (got[i] !== e) begin n_fail++; $display("FAIL clear_entry%0d got %o want %o", i, got[i], e); end
        end
    endtask

    task automatic test_backspace();
        press(8'h1C, 6'o01);
        press(8'h32, 6'o02);
        key(8'h66, 1'b1); m_bs();
        n_tests++;
        if (dut_status() !== exp_status()) begin
            n_fail++; $display("FAIL bs_one_status got %b want %b", dut_status(), exp_status());
        end
        key(8'h66, 1'b1); m_bs();
        key(8'h66, 1'b1); m_bs();
        n_tests++;
        if (dut_status() !== exp_status()) begin
            n_fail++; $display("FAIL bs_empty_status got %b want %b", dut_status(), exp_status());
        end
        press(8'h29, SP);
        press(8'h35, 6'o31);   // must land at entry 1, not wrapped
        read_line();
        for (int i = 0; i < N; i++) begin
            e = exp_q.pop_front(); n_tests++;
            if (got[i] !== e) begin n_fail++; $display("FAIL bs_entry%0d got %o want %o", i, got[i], e); end
        end
    endtask

    task automatic test_full();
        logic [7:0] codes [17];
        codes = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                  8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15};
        enter_and_wait();
        for (int i = 0; i < 16; i++) press(codes[i], 6'(i + 1));
        n_tests++;
        if (dut_status() !== exp_status()) begin
            n_fail++; $display("FAIL full16_status got %b want %b", dut_status(), exp_status());
        end
        press(codes[16], 6'o21);
        n_tests++;
        if (dut_status() !== exp_status()) begin
            n_fail++; $display("FAIL full17_status got %b want %b", dut_status(), exp_status());
        end
        read_line();
        for (int i = 0; i < N; i++) begin
            e = exp_q.pop_front(); n_tests++;
            if (got[i] !== e) begin n_fail++; $display("FAIL full_entry%0d got %o want %o", i, got[i], e); end
        end
        key(8'h66, 1'b1); m_bs();
        n_tests++;
        if (dut_status() !== exp_status()) begin
            n_fail++; $display("FAIL full_bs_status got %b want %b", dut_status(), exp_status());
        end
        enter_and_wait();
        n_tests++;
        if (dut_status() !== exp_status()) begin
            n_fail++; $display("FAIL full_clear_status got %b want %b", dut_status(), exp_status());
        end
    endtask

    task automatic test_rd_collision();
        logic [5:0] g [3];
        press(8'h16, 6'o61);
        press(8'h1E, 6'o62);
        @(negedge clk);
        bus.Rd_valid = 1'b1; bus.Rd_index = 4'd2;
        bus.PS2_code = 8'h26; bus.PS2_make_code = 1'b1; bus.PS2_code_ready = 1'b1;
        exp_q.push_back(exp_mem[2]);
        m_put(6'o63);
        @(posedge clk); #1 g[0] = bus.Rd_char;
        @(negedge clk);
        bus.PS2_code_ready = 1'b0;
        exp_q.push_back(exp_mem[2]);
        @(posedge clk); #1 g[1] = bus.Rd_char;
        @(negedge clk);
        bus.Rd_valid = 1'b0;
        exp_q.push_back(SP);
        @(posedge clk); #1 g[2] = bus.Rd_char;
        for (int i = 0; i < 3; i++) begin
            e = exp_q.pop_front(); n_tests++;
            if (g[i] !== e) begin n_fail++; $display("FAIL rdwr_step%0d got %o want %o", i, g[i], e); end
        end
    endtask

    initial begin
        bus.PS2_code = 8'h00; bus.PS2_code_ready = 1'b0; bus.PS2_make_code = 1'b0;
        bus.Rd_index = '0; bus.Rd_valid = 1'b0;
        test_reset();
        test_basic();
        test_hold_break();
        test_clear();
        test_backspace();
        test_full();
        test_rd_collision();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
